// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with redirect, trap, trap-return and halt control
// Ports: clk; reset (async, active-low); pc current PC; stall holds PC;
//   branch_taken/branch_target and jump/jump_target redirect requests;
//   trap_req, eret, halt control requests; pcNext combinational next PC;
//   flush, epc, cause, status, in_trap registered control and trap state.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic        eret,
  input  logic        halt,
  output logic [31:0] pcNext,
  output logic        flush,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [1:0]  status,
  output logic        in_trap
);
  typedef enum logic [1:0] {RUN = 2'd0, REDIRECT = 2'd1, HALTED = 2'd2} state_t;
  state_t state, state_d;
  logic [31:0] pc_d, epc_d, tgt;
  logic [1:0] cause_d;
  logic trap_d, redir, misal, trap_ev;
  // jump outranks branch, so only the target actually selected is alignment-checked
  assign tgt = jump ? jump_target : branch_target;
  assign redir = jump | branch_taken;
  assign misal = redir & (tgt[1:0] != 2'b00);
  assign trap_ev = trap_req | misal;
  always_comb begin
    state_d = RUN;
    pc_d = pc + 32'd4;
    epc_d = epc;
    cause_d = cause;
    trap_d = in_trap;
    if (state == HALTED) begin
      state_d = HALTED;
      pc_d = pc;
      if (trap_req && !in_trap) begin
        state_d = REDIRECT;
        pc_d = TRAP_VEC;
        epc_d = pc;
        cause_d = 2'd1;
        trap_d = 1'b1;
      end
    end else if (trap_ev && in_trap) begin
      // a trap inside the handler is unrecoverable: freeze until reset
      state_d = HALTED;
      pc_d = pc;
      cause_d = 2'd3;
    end else if (trap_ev) begin
      state_d = REDIRECT;
      pc_d = TRAP_VEC;
      epc_d = pc;
      cause_d = trap_req ? 2'd1 : 2'd2;
      trap_d = 1'b1;
    end else if (eret && in_trap) begin
      state_d = REDIRECT;
      pc_d = epc;
      cause_d = 2'd0;
      trap_d = 1'b0;
    end else if (redir) begin
      state_d = REDIRECT;
      pc_d = tgt;
    end else if (halt) begin
      state_d = HALTED;
      pc_d = pc;
    end else if (stall) begin
      pc_d = pc;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      epc <= 32'd0;
      cause <= 2'd0;
      in_trap <= 1'b0;
    end else begin
      state <= state_d;
      epc <= epc_d;
      cause <= cause_d;
      in_trap <= trap_d;
    end
  end
  assign pcNext = reset ? pc_d : RESET_VEC;
  assign flush = state == REDIRECT;
  assign status = state;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, corner sequences and random run against a reference model
module tb_pc_sequencer;
  logic clk, reset, stall, branch_taken, jump, trap_req, eret, halt;
  logic [31:0] pc, branch_target, jump_target;
  logic [31:0] pcNext, epc;
  logic flush, in_trap;
  logic [1:0] cause, status;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .trap_req(trap_req), .eret(eret), .halt(halt),
    .pcNext(pcNext), .flush(flush), .epc(epc), .cause(cause),
    .status(status), .in_trap(in_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  ev;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] e_pn;
    logic [1:0]  e_st;
    logic        e_fl;
    logic [31:0] e_epc;
    logic [1:0]  e_cause;
    logic        e_it;
  } vec_t;

  localparam logic [5:0] NONE = 6'b000000, STALL = 6'b100000, BR = 6'b010000,
                         JMP = 6'b001000, TRAP = 6'b000100, ERET = 6'b000010, HALT = 6'b000001;

  int errors = 0;
  int checks = 0;

  int m_st;
  logic [31:0] m_epc;
  int m_cause;
  bit m_it;

  function automatic vec_t mk(logic [31:0] p, logic [5:0] ev, logic [31:0] bt, logic [31:0] jt,
                              logic [31:0] pn, logic [1:0] st, logic fl, logic [31:0] e,
                              logic [1:0] c, logic it);
    vec_t v;
    v.pc = p; v.ev = ev; v.bt = bt; v.jt = jt;
    v.e_pn = pn; v.e_st = st; v.e_fl = fl; v.e_epc = e; v.e_cause = c; v.e_it = it;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the winning event from the priority list, then apply its effect.
  task automatic model(input vec_t v, output logic [31:0] pn);
    logic [31:0] tgt;
    int ev;
    tgt = v.ev[3] ? v.jt : v.bt;
    if (m_st == 2) begin
      ev = (v.ev[2] && !m_it) ? 6 : -1;
    end else if (v.ev[2]) ev = 6;
    else if ((v.ev[3] || v.ev[4]) && (tgt % 4 != 0)) ev = 5;
    else if (v.ev[1] && m_it) ev = 4;
    else if (v.ev[3] || v.ev[4]) ev = 3;
    else if (v.ev[0]) ev = 2;
    else if (v.ev[5]) ev = 1;
    else ev = 0;
    pn = v.pc;
    if (ev >= 5 && m_it) begin
      m_cause = 3; m_st = 2;
    end else if (ev >= 5) begin
      pn = 32'h80; m_epc = v.pc; m_cause = (ev == 6) ? 1 : 2; m_it = 1; m_st = 1;
    end else if (ev == 4) begin
      pn = m_epc; m_it = 0; m_cause = 0; m_st = 1;
    end else if (ev == 3) begin
      pn = tgt; m_st = 1;
    end else if (ev == 2) begin
      m_st = 2;
    end else if (ev == 1) begin
      m_st = 0;
    end else if (ev == 0) begin
      pn = v.pc + 32'd4; m_st = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t v, input bit use_model, input string tag);
    logic [31:0] pn;
    pc = v.pc; branch_target = v.bt; jump_target = v.jt;
    {stall, branch_taken, jump, trap_req, eret, halt} = v.ev;
    model(v, pn);
    if (use_model) begin
      v.e_pn = pn; v.e_st = 2'(m_st); v.e_fl = (m_st == 1); v.e_epc = m_epc;
      v.e_cause = 2'(m_cause); v.e_it = m_it;
    end
    #1;
    check({tag, " pcNext"}, pcNext, v.e_pn);
    @(posedge clk);
    #1;
    check({tag, " status"}, 32'(status), 32'(v.e_st));
    check({tag, " flush"}, 32'(flush), 32'(v.e_fl));
    check({tag, " epc"}, epc, v.e_epc);
    check({tag, " cause"}, 32'(cause), 32'(v.e_cause));
    check({tag, " in_trap"}, 32'(in_trap), 32'(v.e_it));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst status", 32'(status), 32'd0);
    check("rst flush", 32'(flush), 32'd0);
    check("rst pcNext", pcNext, 32'h0);
    check("rst epc", epc, 32'h0);
    check("rst cause", 32'(cause), 32'd0);
    check("rst in_trap", 32'(in_trap), 32'd0);
    m_st = 0; m_epc = 32'h0; m_cause = 0; m_it = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[13];
  vec_t v;

  initial begin
    reset = 1'b0; pc = 32'h0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    trap_req = 1'b0; eret = 1'b0; halt = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
    tbl[0]  = mk(32'h100, NONE,      32'h0,   32'h0,   32'h104, 2'd0, 1'b0, 32'h0,   2'd0, 1'b0);
    tbl[1]  = mk(32'h100, STALL,     32'h0,   32'h0,   32'h100, 2'd0, 1'b0, 32'h0,   2'd0, 1'b0);
    tbl[2]  = mk(32'h100, BR | JMP,  32'h200, 32'h300, 32'h300, 2'd1, 1'b1, 32'h0,   2'd0, 1'b0);
    tbl[3]  = mk(32'h300, NONE,      32'h0,   32'h0,   32'h304, 2'd0, 1'b0, 32'h0,   2'd0, 1'b0);
    tbl[4]  = mk(32'h140, JMP,       32'h0,   32'h202, 32'h80,  2'd1, 1'b1, 32'h140, 2'd2, 1'b1);
    tbl[5]  = mk(32'h80,  ERET,      32'h0,   32'h0,   32'h140, 2'd1, 1'b1, 32'h140, 2'd0, 1'b0);
    tbl[6]  = mk(32'h140, ERET,      32'h0,   32'h0,   32'h144, 2'd0, 1'b0, 32'h140, 2'd0, 1'b0);
    tbl[7]  = mk(32'h40,  TRAP,      32'h0,   32'h0,   32'h80,  2'd1, 1'b1, 32'h40,  2'd1, 1'b1);
    tbl[8]  = mk(32'h90,  ERET,      32'h0,   32'h0,   32'h40,  2'd1, 1'b1, 32'h40,  2'd0, 1'b0);
    tbl[9]  = mk(32'h40,  TRAP|STALL,32'h0,   32'h0,   32'h80,  2'd1, 1'b1, 32'h40,  2'd1, 1'b1);
    tbl[10] = mk(32'h84,  TRAP,      32'h0,   32'h0,   32'h84,  2'd2, 1'b0, 32'h40,  2'd3, 1'b1);
    tbl[11] = mk(32'h88,  JMP | ERET,32'h0,   32'h100, 32'h88,  2'd2, 1'b0, 32'h40,  2'd3, 1'b1);
    tbl[12] = mk(32'h88,  TRAP,      32'h0,   32'h0,   32'h88,  2'd2, 1'b0, 32'h40,  2'd3, 1'b1);
    @(negedge clk);
    do_reset();
    foreach (tbl[i]) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));

    do_reset();
    apply(mk(32'hFFFF_FFFC, NONE, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0), 1'b0, "wrap");
    apply(mk(32'h10, STALL | BR, 32'h400, 32'h0, 32'h400, 2'd1, 1'b1, 32'h0, 2'd0, 1'b0), 1'b0, "stall_br");
    apply(mk(32'h400, BR, 32'h500, 32'h0, 32'h500, 2'd1, 1'b1, 32'h0, 2'd0, 1'b0), 1'b0, "b2b");
    apply(mk(32'h500, STALL, 32'h0, 32'h0, 32'h500, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0), 1'b0, "redir_stall");
    apply(mk(32'h20, HALT, 32'h0, 32'h0, 32'h20, 2'd2, 1'b0, 32'h0, 2'd0, 1'b0), 1'b0, "halt");
    for (int i = 0; i < 5; i++)
      apply(mk(32'h20, JMP | HALT, 32'h0, 32'h300, 32'h20, 2'd2, 1'b0, 32'h0, 2'd0, 1'b0), 1'b0, "halt_hold");
    apply(mk(32'h20, TRAP, 32'h0, 32'h0, 32'h80, 2'd1, 1'b1, 32'h20, 2'd1, 1'b1), 1'b0, "halt_trap");

    apply(mk(32'h100, JMP, 32'h0, 32'h500, 32'h500, 2'd1, 1'b1, 32'h20, 2'd1, 1'b1), 1'b0, "pre_rst");
    #2;
    do_reset();
    apply(mk(32'h500, NONE, 32'h0, 32'h0, 32'h504, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0), 1'b0, "post_rst");

    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      if ($urandom_range(0, 63) == 0 || (m_st == 2 && m_it && $urandom_range(0, 3) == 0)) do_reset();
      r = $urandom;
      v.pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
      r = $urandom;
      v.bt = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom;
      v.jt = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
      v.ev = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0};
      apply(v, 1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_VEC, default 32'h0000_0000, giving the pcNext value driven while reset is asserted.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0080, giving the trap handler entry address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port pc, input, 32 bits: current program counter from the PC register.
REQ-006 The block SHALL have port stall, input, 1 bit: hold PC this cycle.
REQ-007 The block SHALL have ports branch_taken, input, 1 bit, and branch_target, input, 32 bits: conditional redirect.
REQ-008 The block SHALL have ports jump, input, 1 bit, and jump_target, input, 32 bits: unconditional redirect.
REQ-009 The block SHALL have ports trap_req, eret and halt, each input, 1 bit: trap entry, trap return and halt request.
REQ-010 The block SHALL have port pcNext, output, 32 bits: combinational next-PC, fed to the PC register.
REQ-011 The block SHALL have port flush, output, 1 bit: registered, kills the instruction fetched on the wrong path.
REQ-012 The block SHALL have port epc, output, 32 bits: registered exception return address.
REQ-013 The block SHALL have port cause, output, 2 bits: registered trap cause (0 none, 1 trap_req, 2 misaligned, 3 double fault).
REQ-014 The block SHALL have port status, output, 2 bits: registered FSM state (0 RUN, 1 REDIRECT, 2 HALTED).
REQ-015 The block SHALL have port in_trap, output, 1 bit: registered, high between trap entry and eret.

Function
REQ-016 The FSM SHALL have three states: RUN, REDIRECT and HALTED.
REQ-017 In RUN and REDIRECT, the event priority SHALL be trap_req > misaligned target > eret (only if in_trap) > jump > branch_taken > halt > stall > sequential.
REQ-018 The sequential case SHALL drive pcNext = pc + 4, with 32-bit arithmetic wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 The stall case SHALL drive pcNext = pc, with no state change.
REQ-020 On jump or branch_taken with target[1:0] == 0, pcNext SHALL be the target, and the next state SHALL be REDIRECT.
REQ-021 A selected jump or branch target with target[1:0] != 0 SHALL be treated as a trap with cause 2.
REQ-022 On a trap while in_trap = 0: pcNext = TRAP_VEC; epc <= pc; cause <= 1 or 2; in_trap <= 1; next state = REDIRECT.
REQ-023 On a trap while in_trap = 1: pcNext = pc; cause <= 3; epc unchanged; next state = HALTED.
REQ-024 On eret while in_trap = 1: pcNext = epc; in_trap <= 0; cause <= 0; next state = REDIRECT.
REQ-025 An eret while in_trap = 0 SHALL be ignored.
REQ-026 In RUN, halt (with no higher-priority event) SHALL drive pcNext = pc, and the next state SHALL be HALTED.
REQ-027 flush SHALL equal 1 exactly while status == REDIRECT, for one cycle per redirect.
REQ-028 Back-to-back redirects (a redirect accepted while in REDIRECT) SHALL keep status at REDIRECT and flush high.
REQ-029 REDIRECT with no new event SHALL return to RUN.
REQ-030 stall SHALL NOT suppress or delay a redirect or trap.
REQ-031 In HALTED: pcNext = pc; jump, branch, eret, halt and stall SHALL be ignored.
REQ-032 In HALTED, trap_req SHALL exit to REDIRECT with TRAP_VEC entry per REQ-022 only if in_trap = 0; otherwise HALTED SHALL persist until reset.

Reset
REQ-033 While reset is low, asynchronously: status = RUN, flush = 0, epc = 0, cause = 0, in_trap = 0, pcNext = RESET_VEC.
REQ-034 Reset asserted mid-redirect or mid-trap SHALL discard all pending state; the first cycle after release SHALL be RUN with pcNext = pc + 4.

Verification
REQ-035 The bench SHALL cover: pc = 32'h100, no events -> pcNext = 32'h104, flush = 0; stall = 1 -> pcNext = 32'h100.
REQ-036 The bench SHALL cover: pc = 32'h100, branch_taken = 1, target = 32'h200, with jump = 1, jump_target = 32'h300 in the same cycle -> pcNext = 32'h300, flush = 1 next cycle only.
REQ-037 The bench SHALL cover: pc = 32'h140, jump_target = 32'h202 -> pcNext = 32'h80, epc = 32'h140, cause = 2, in_trap = 1.
REQ-038 The bench SHALL cover: trap taken at pc = 32'h40, then eret at pc = 32'h90 -> pcNext = 32'h40, in_trap = 0; a second trap_req before eret -> status = HALTED, cause = 3.
REQ-039 The bench SHALL cover: halt at pc = 32'h20 -> pcNext held at 32'h20 over 5 cycles with jump pulses; trap_req -> pcNext = 32'h80.
REQ-040 The bench SHALL cover: reset pulled low during REDIRECT -> flush = 0 immediately, pcNext = 32'h0; release -> normal sequencing.
